// File: rtl/spi_cfg_target.sv
// SPI mode-0 target for the 40/56-bit ADC configuration protocol.
// Oversamples the SPI pins on clk, emits register write/read strobes and serves reads on miso.
module spi_cfg_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] OP_WRITE    = 8'h02,
  parameter logic [7:0] OP_READ     = 8'h03,
  parameter logic [7:0] OP_NOP      = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [15:0] reg_addr,
  output logic [15:0] reg_wdata,
  input  logic [15:0] reg_rdata,
  output logic        ext_frame,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, EVAL} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_q, cs_q;
  logic [55:0]            shift_reg;
  logic [5:0]             bit_cnt;
  logic [15:0]            miso_sr;
  logic                   rd_armed;

  logic        sclk_s, cs_s, mosi_s;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [55:0] shift_next;
  logic [39:0] frame;
  logic [7:0]  frame_op;
  logic        len_ok;

  // cs resets to 0 so a cs already low at reset release does not look like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      cs_q      <= cs_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sclk_s     = sclk_sync[SYNC_STAGES-1];
    cs_s       = cs_sync[SYNC_STAGES-1];
    mosi_s     = mosi_sync[SYNC_STAGES-1];
    sclk_rise  = sclk_s & ~sclk_q;
    sclk_fall  = ~sclk_s & sclk_q;
    cs_rise    = cs_s & ~cs_q;
    cs_fall    = ~cs_s & cs_q;
    shift_next = {shift_reg[54:0], mosi_s};
    len_ok     = (bit_cnt == 6'd40) || (bit_cnt == 6'd56);
    frame      = (bit_cnt == 6'd56) ? shift_reg[55:16] : shift_reg[39:0];
    frame_op   = frame[39:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      miso_sr     <= '0;
      rd_armed    <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      ext_frame   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      ext_frame <= 1'b0;
      frame_err <= 1'b0;

      // Read data is captured the cycle after the request strobe.
      if (reg_rd) begin
        miso_sr  <= reg_rdata;
        rd_armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end
        end

        SHIFT: begin
          // A cs rise wins over a coincident sclk rise, so the last bit is not counted.
          if (cs_rise) begin
            state       <= EVAL;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            rd_armed    <= 1'b0;
          end else begin
            if (sclk_rise) begin
              shift_reg <= shift_next;
              if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd23 && shift_next[23:16] == OP_READ) begin
                reg_rd   <= 1'b1;
                reg_addr <= shift_next[15:0];
              end
            end
            if (sclk_fall) begin
              if (rd_armed) begin
                spi_miso_oe <= 1'b1;
                spi_miso    <= miso_sr[15];
                miso_sr     <= {miso_sr[14:0], 1'b0};
                rd_armed    <= 1'b0;
              end else if (spi_miso_oe) begin
                if (bit_cnt >= 6'd40) begin
                  spi_miso_oe <= 1'b0;
                  spi_miso    <= 1'b0;
                end else begin
                  spi_miso <= miso_sr[15];
                  miso_sr  <= {miso_sr[14:0], 1'b0};
                end
              end
            end
          end
        end

        EVAL: begin
          state <= IDLE;
          if (len_ok) begin
            ext_frame <= (bit_cnt == 6'd56);
            if (frame_op == OP_WRITE) begin
              reg_wr    <= 1'b1;
              reg_addr  <= frame[31:16];
              reg_wdata <= frame[15:0];
            end else if (frame_op != OP_READ && frame_op != OP_NOP) begin
              frame_err <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
